// File: rtl/ex_mdu_pkg.sv
// Shared defines for the execute-stage multiply/divide unit:
// ALU op codes, result-select classes and divider FSM states.
package ex_mdu_pkg;

  // ALU operation codes
  localparam logic [7:0] OP_NOP   = 8'h00;
  localparam logic [7:0] OP_AND   = 8'h24;
  localparam logic [7:0] OP_OR    = 8'h25;
  localparam logic [7:0] OP_XOR   = 8'h26;
  localparam logic [7:0] OP_NOR   = 8'h27;
  localparam logic [7:0] OP_SLL   = 8'h7C;
  localparam logic [7:0] OP_SRL   = 8'h02;
  localparam logic [7:0] OP_SRA   = 8'h03;
  localparam logic [7:0] OP_ADDU  = 8'h21;
  localparam logic [7:0] OP_SUBU  = 8'h23;
  localparam logic [7:0] OP_SLT   = 8'h2A;
  localparam logic [7:0] OP_SLTU  = 8'h2B;
  localparam logic [7:0] OP_MFHI  = 8'h10;
  localparam logic [7:0] OP_MTHI  = 8'h11;
  localparam logic [7:0] OP_MFLO  = 8'h12;
  localparam logic [7:0] OP_MTLO  = 8'h13;
  localparam logic [7:0] OP_MULT  = 8'h18;
  localparam logic [7:0] OP_MULTU = 8'h19;
  localparam logic [7:0] OP_DIV   = 8'h1A;
  localparam logic [7:0] OP_DIVU  = 8'h1B;

  // ALU result-select classes
  localparam logic [2:0] SEL_NOP   = 3'b000;
  localparam logic [2:0] SEL_LOGIC = 3'b001;
  localparam logic [2:0] SEL_SHIFT = 3'b010;
  localparam logic [2:0] SEL_MOVE  = 3'b011;
  localparam logic [2:0] SEL_ARITH = 3'b100;

  // Iterative divider states
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DIV_ON   = 2'd1,
    DIV_ZERO = 2'd2,
    DIV_END  = 2'd3
  } div_state_e;

endpackage

// File: rtl/ex_mdu_if.sv
// Execute-stage bus between the pipeline (master) and the MDU (slave).
interface ex_mdu_if #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 5,
  parameter int OP_W   = 8,
  parameter int SEL_W  = 3
);
  logic [OP_W-1:0]   aluop_i;
  logic [SEL_W-1:0]  alusel_i;
  logic [WIDTH-1:0]  reg1_i;
  logic [WIDTH-1:0]  reg2_i;
  logic [ADDR_W-1:0] wd_i;
  logic              wreg_i;
  logic              flush_i;
  logic [ADDR_W-1:0] wd_o;
  logic              wreg_o;
  logic [WIDTH-1:0]  wdata_o;
  logic              stallreq_o;
  logic [WIDTH-1:0]  hi_o;
  logic [WIDTH-1:0]  lo_o;

  modport master (
    output aluop_i, alusel_i, reg1_i, reg2_i, wd_i, wreg_i, flush_i,
    input  wd_o, wreg_o, wdata_o, stallreq_o, hi_o, lo_o
  );

  modport slave (
    input  aluop_i, alusel_i, reg1_i, reg2_i, wd_i, wreg_i, flush_i,
    output wd_o, wreg_o, wdata_o, stallreq_o, hi_o, lo_o
  );
endinterface

// File: rtl/ex_mdu_div_iter.sv
// Restoring divider, one quotient bit per cycle. Works on magnitudes and
// fixes signs on the last iteration; ready is high exactly in DIV_END.
module div_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             annul,
  input  logic             signed_div,
  input  logic [WIDTH-1:0] opdata1,
  input  logic [WIDTH-1:0] opdata2,
  output logic             ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);
  import ex_mdu_pkg::*;

  localparam int CNT_W = $clog2(WIDTH) + 1;

  div_state_e       state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] dvd_q, dvs, rem;
  logic             neg_q, neg_r;
  logic [WIDTH-1:0] abs1, abs2, rem_nxt, q_nxt;
  logic [WIDTH:0]   shifted, diff;

  // Operand magnitudes and one restoring step (shifted < 2*dvs, so W+1 bits suffice)
  always_comb begin
    abs1    = (signed_div && opdata1[WIDTH-1]) ? -opdata1 : opdata1;
    abs2    = (signed_div && opdata2[WIDTH-1]) ? -opdata2 : opdata2;
    shifted = {rem, dvd_q[WIDTH-1]};
    diff    = shifted - {1'b0, dvs};
    rem_nxt = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
    q_nxt   = {dvd_q[WIDTH-2:0], ~diff[WIDTH]};
  end

  // Divider FSM; annul (flush) drops any divide without producing a result
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      dvd_q     <= '0;
      dvs       <= '0;
      rem       <= '0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      ready     <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
    end else if (annul) begin
      state <= IDLE;
      cnt   <= '0;
      ready <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          if (opdata2 == '0) begin
            state <= DIV_ZERO;
          end else begin
            dvd_q <= abs1;
            dvs   <= abs2;
            rem   <= '0;
            neg_q <= signed_div && (opdata1[WIDTH-1] ^ opdata2[WIDTH-1]);
            neg_r <= signed_div && opdata1[WIDTH-1];
            cnt   <= '0;
            state <= DIV_ON;
          end
        end
        DIV_ZERO: begin
          quotient  <= '0;
          remainder <= '0;
          ready     <= 1'b1;
          state     <= DIV_END;
        end
        DIV_ON: begin
          dvd_q <= q_nxt;
          rem   <= rem_nxt;
          cnt   <= cnt + 1'b1;
          if (cnt == CNT_W'(WIDTH - 1)) begin
            quotient  <= neg_q ? -q_nxt : q_nxt;
            remainder <= neg_r ? -rem_nxt : rem_nxt;
            ready     <= 1'b1;
            cnt       <= '0;
            state     <= DIV_END;
          end
        end
        DIV_END: begin
          ready <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: rtl/ex_mdu.sv
// Execute stage: single-cycle ALU result mux, HI/LO registers, multiplier
// and the iterative divider with its pipeline stall request.
module ex_mdu #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 5,
  parameter int OP_W   = 8,
  parameter int SEL_W  = 3
) (
  input  logic   clk,
  input  logic   rst,
  ex_mdu_if.slave bus
);
  import ex_mdu_pkg::*;

  localparam int SH_W = $clog2(WIDTH);

  logic [OP_W-1:0]    op;
  logic [SEL_W-1:0]   sel;
  logic [WIDTH-1:0]   a, b, hi, lo, res, quo, rmd;
  logic [SH_W-1:0]    sh;
  logic [2*WIDTH-1:0] mul_a, mul_b, prod;
  logic               is_mul, is_div, hilo_only, div_ready;

  assign op        = bus.aluop_i;
  assign sel       = bus.alusel_i;
  assign a         = bus.reg1_i;
  assign b         = bus.reg2_i;
  assign sh        = a[SH_W-1:0];
  assign is_mul    = (op == OP_MULT) || (op == OP_MULTU);
  assign is_div    = (op == OP_DIV)  || (op == OP_DIVU);
  assign hilo_only = is_mul || is_div || (op == OP_MTHI) || (op == OP_MTLO);

  // One 2W x 2W multiplier; the low 2W bits are the correct signed or unsigned product
  assign mul_a = (op == OP_MULT) ? {{WIDTH{a[WIDTH-1]}}, a} : {{WIDTH{1'b0}}, a};
  assign mul_b = (op == OP_MULT) ? {{WIDTH{b[WIDTH-1]}}, b} : {{WIDTH{1'b0}}, b};
  assign prod  = mul_a * mul_b;

  div_iter #(.WIDTH(WIDTH)) u_div (
    .clk        (clk),
    .rst        (rst),
    .start      (is_div),
    .annul      (bus.flush_i),
    .signed_div (op == OP_DIV),
    .opdata1    (a),
    .opdata2    (b),
    .ready      (div_ready),
    .quotient   (quo),
    .remainder  (rmd)
  );

  // Single-cycle result; anything not decoded yields zero
  always_comb begin
    res = '0;
    case (sel)
      SEL_LOGIC: case (op)
        OP_OR:   res = a | b;
        OP_AND:  res = a & b;
        OP_XOR:  res = a ^ b;
        OP_NOR:  res = ~(a | b);
        default: res = '0;
      endcase
      SEL_SHIFT: case (op)
        OP_SLL:  res = b << sh;
        OP_SRL:  res = b >> sh;
        OP_SRA:  res = $signed(b) >>> sh;
        default: res = '0;
      endcase
      SEL_ARITH: case (op)
        OP_ADDU: res = a + b;
        OP_SUBU: res = a - b;
        OP_SLT:  res = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
        OP_SLTU: res = {{(WIDTH-1){1'b0}}, a < b};
        default: res = '0;
      endcase
      SEL_MOVE: case (op)
        OP_MFHI: res = hi;
        OP_MFLO: res = lo;
        default: res = '0;
      endcase
      default: res = '0;
    endcase
  end

  // HI/LO update: flush blocks all writes; divide result beats MULT beats MTHI/MTLO
  always_ff @(posedge clk) begin
    if (rst) begin
      hi <= '0;
      lo <= '0;
    end else if (!bus.flush_i) begin
      if (div_ready) begin
        lo <= quo;
        hi <= rmd;
      end else if (is_mul) begin
        {hi, lo} <= prod;
      end else if (op == OP_MTHI) begin
        hi <= a;
      end else if (op == OP_MTLO) begin
        lo <= a;
      end
    end
  end

  // Stall while a divide is pending and its result is not yet ready
  assign bus.stallreq_o = !rst && is_div && !div_ready && !bus.flush_i;
  assign bus.wd_o       = rst ? ADDR_W'(0) : bus.wd_i;
  assign bus.wreg_o     = !rst && bus.wreg_i && !hilo_only;
  assign bus.wdata_o    = rst ? '0 : res;
  assign bus.hi_o       = hi;
  assign bus.lo_o       = lo;
endmodule
